// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: FIFO of {instruction, pc} between fetch and decode.
// Ports: clk, reset, flush, enq_* (fetch side), deq_* (decode side), count.
module instruction_fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     enq_valid,
   input  logic [31:0]              enq_instruction,
   input  logic [XLEN-1:0]          enq_pc,
   output logic                     enq_ready,
   output logic                     deq_valid,
   output logic [31:0]              deq_instruction,
   output logic [XLEN-1:0]          deq_pc,
   input  logic                     deq_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     occ;
   logic            enq_fire;
   logic            deq_fire;

   // Ready/valid depend only on registered occupancy, never on the
   // opposite handshake input.
   assign enq_ready = (occ != FULL);
   assign deq_valid = (occ != '0);
   assign count     = occ;

   assign enq_fire = enq_valid && enq_ready && !flush;
   assign deq_fire = deq_valid && deq_ready && !flush;

   assign head            = mem[rd_ptr];
   assign deq_instruction = deq_valid ? head.instr : '0;
   assign deq_pc          = deq_valid ? head.pc    : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (enq_fire) begin
            mem[wr_ptr] <= '{instr: enq_instruction, pc: enq_pc};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (deq_fire)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({enq_fire, deq_fire})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue.
// Drives fetch/decode handshakes, flush and reset; checks order and flags.
module tb_instruction_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              enq_valid;
   logic [31:0]       enq_instruction;
   logic [XLEN-1:0]   enq_pc;
   logic              enq_ready;
   logic              deq_valid;
   logic [31:0]       deq_instruction;
   logic [XLEN-1:0]   deq_pc;
   logic              deq_ready;
   logic [2:0]        count;

   int                tests  = 0;
   int                fails  = 0;
   int                mcount = 0;
   logic [63:0]       sb [$];

   instruction_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .enq_valid       (enq_valid),
      .enq_instruction (enq_instruction),
      .enq_pc          (enq_pc),
      .enq_ready       (enq_ready),
      .deq_valid       (deq_valid),
      .deq_instruction (deq_instruction),
      .deq_pc          (deq_pc),
      .deq_ready       (deq_ready),
      .count           (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Checks the current state against the model, then advances one edge.
   task automatic tick();
      bit ef;
      bit df;
      logic [63:0] e;
      check("count", 64'(count), 64'(mcount));
      check("enq_ready", 64'(enq_ready), 64'(mcount != DEPTH));
      check("deq_valid", 64'(deq_valid), 64'(mcount != 0));
      if (mcount == 0) begin
         check("idle_instr", 64'(deq_instruction), 64'h0);
         check("idle_pc", 64'(deq_pc), 64'h0);
      end
      ef = enq_valid && (mcount != DEPTH) && !flush && !reset;
      df = deq_ready && (mcount != 0) && !flush && !reset;
      if (df) begin
         e = sb.pop_front();
         check("deq_instr", 64'(deq_instruction), 64'(e[63:32]));
         check("deq_pc", 64'(deq_pc), 64'(e[31:0]));
      end
      @(posedge clk);
      if (reset || flush) begin
         sb.delete();
         mcount = 0;
      end else begin
         if (ef) sb.push_back({enq_instruction, enq_pc});
         mcount = mcount + int'(ef) - int'(df);
      end
      #1;
   endtask

   function automatic logic [31:0] word(input logic [31:0] pc);
      return 32'hA5000013 ^ (pc << 7);
   endfunction

   task automatic set_enq(input logic [31:0] pc);
      enq_valid       = 1'b1;
      enq_pc          = pc;
      enq_instruction = word(pc);
   endtask

   task automatic fill(input int n, input logic [31:0] base);
      deq_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         set_enq(base + 32'(4 * i));
         tick();
      end
      enq_valid = 1'b0;
   endtask

   task automatic drain();
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      for (int i = 0; i < 2 * DEPTH && mcount != 0; i++)
         tick();
      deq_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      enq_valid = 1'b0;
      enq_instruction = '0;
      enq_pc = '0;
      deq_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      mcount = 0;

      // 1: single enq, visible next cycle
      enq_valid = 1'b1;
      enq_instruction = 32'h00500093;
      enq_pc = 32'h0;
      tick();
      enq_valid = 1'b0;
      check("t1_valid", 64'(deq_valid), 64'h1);
      check("t1_instr", 64'(deq_instruction), 64'h00500093);
      check("t1_pc", 64'(deq_pc), 64'h0);
      check("t1_count", 64'(count), 64'h1);
      drain();
      tick();

      // 2: fill to full, 5th refused, drain in order
      fill(4, 32'h0);
      check("t2_count", 64'(count), 64'h4);
      check("t2_ready", 64'(enq_ready), 64'h0);
      set_enq(32'h10);
      tick();
      tick();
      enq_valid = 1'b0;
      drain();
      check("t2_empty", 64'(deq_valid), 64'h0);

      // 3: steady enq+deq at count 2, pointers wrap
      fill(2, 32'h100);
      deq_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_enq(32'h108 + 32'(4 * i));
         tick();
      end
      check("t3_count", 64'(count), 64'h2);
      drain();

      // 4: full with enq and deq together: only deq fires
      fill(4, 32'h200);
      set_enq(32'h210);
      deq_ready = 1'b1;
      tick();
      check("t4_count", 64'(count), 64'h3);
      deq_ready = 1'b0;
      tick();
      enq_valid = 1'b0;
      check("t4_full", 64'(count), 64'h4);
      drain();

      // 5: flush beats same-cycle enq/deq
      fill(3, 32'h300);
      flush = 1'b1;
      set_enq(32'h30C);
      deq_ready = 1'b1;
      tick();
      flush = 1'b0;
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      check("t5_count", 64'(count), 64'h0);
      check("t5_ready", 64'(enq_ready), 64'h1);
      fill(1, 32'h320);
      check("t5_pc", 64'(deq_pc), 64'h320);
      drain();

      // 6: reset mid-stream
      fill(2, 32'h400);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_count", 64'(count), 64'h0);
      check("t6_instr", 64'(deq_instruction), 64'h0);
      fill(1, 32'h40);
      check("t6_pc", 64'(deq_pc), 64'h40);
      drain();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
